rec_addr_gen: RTL and testbench

//  Multi-slot record/playback address generator for the audio recorder datapath.

---
 rtl/rec_addr_gen_if.sv | 33 +++
 rtl/rec_addr_gen.sv | 150 +++++++++++++++
 tb/tb_rec_addr_gen.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rec_addr_gen_if.sv
// Control/RAM-side bundle of the record/playback address generator.
// The master side (control FSM) drives the requests and the sample
// strobes; the slave side (rec_addr_gen) drives the RAM address and status.
interface rec_addr_gen_if #(
  parameter int ADDR_W = 17,
  parameter int SLOT_W = 2
);
  logic              start_rec;
  logic              start_play;
  logic              stop;
  logic              timer_done;
  logic [SLOT_W-1:0] slot_sel;
  logic              loop_en;
  logic              des_done;
  logic              ser_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              slot_full;

  modport master (
    output start_rec, start_play, stop, timer_done, slot_sel, loop_en,
           des_done, ser_done,
    input  mem_addr, mem_we, busy, done, slot_full
  );

  modport slave (
    input  start_rec, start_play, stop, timer_done, slot_sel, loop_en,
           des_done, ser_done,
    output mem_addr, mem_we, busy, done, slot_full
  );
endinterface

// File: rtl/rec_addr_gen.sv
// Multi-slot record/playback address generator for the audio recorder.
// Sample memory is split into NUM_SLOTS equal regions. The pointer is kept
// as a slot index plus an in-slot offset, so the address can never leave
// the active slot region. Each slot remembers how many samples it holds.
module rec_addr_gen #(
  parameter int ADDR_W    = 17,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input logic           clock,
  input logic           reset,
  rec_addr_gen_if.slave bus
);

  localparam int OFF_W = ADDR_W - SLOT_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [SLOT_W-1:0]                 cur_q, cur_d;
  logic [OFF_W-1:0]                  off_q, off_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0][CNT_W-1:0]   len_q, len_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              full_q, full_d;

  logic             abort;
  logic [CNT_W-1:0] cnt_inc;

  assign abort   = bus.stop | bus.timer_done;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic: request acceptance, pointer stepping and slot lengths.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    full_d  = full_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_rec) begin
          state_d = RECORD;
          cur_d   = bus.slot_sel;
          off_d   = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
        end else if (bus.start_play) begin
          if (len_q[bus.slot_sel] == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PLAY;
            cur_d   = bus.slot_sel;
            off_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      RECORD: begin
        if (bus.des_done) begin
          if (cnt_inc == DEPTH) begin
            len_d[cur_q] = DEPTH;
            full_d       = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            off_d = off_q + OFF_W'(1);
            cnt_d = cnt_inc;
            if (abort) begin
              len_d[cur_q] = cnt_inc;
              done_d       = 1'b1;
              state_d      = IDLE;
            end
          end
        end else if (abort) begin
          len_d[cur_q] = cnt_q;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end

      PLAY: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.ser_done) begin
          if (cnt_inc == len_q[cur_q]) begin
            if (bus.loop_en) begin
              off_d = '0;
              cnt_d = '0;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            off_d = off_q + OFF_W'(1);
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything including lengths.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  assign bus.mem_addr  = {cur_q, off_q};
  assign bus.mem_we    = bus.des_done && (state_q == RECORD);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.slot_full = full_q;

endmodule

// File: tb/tb_rec_addr_gen.sv
// Self-checking bench for rec_addr_gen (ADDR_W=6, 4 slots of 16 words).
module tb_rec_addr_gen;

  localparam int ADDR_W    = 6;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int DEPTH     = 16;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rec_addr_gen_if #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W)) bus ();

  rec_addr_gen #(
    .ADDR_W(ADDR_W),
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_W(SLOT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic       srec;
    logic       splay;
    logic       stp;
    logic       tmr;
    logic [1:0] sel;
    logic       loop;
    logic       des;
    logic       ser;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  we;
    int    pre_addr;
    logic  busy;
    logic  done;
    logic  full;
    int    post_addr;
  } vec_t;

  int tests_run    = 0;
  int tests_failed = 0;

  logic act_we, act_busy, act_done, act_full;
  int   act_pre_addr, act_post_addr;
  logic exp_we;
  int   exp_pre_addr;

  // Behavioural reference: 0 idle, 1 recording, 2 playing.
  int m_state, m_slot, m_addr, m_cnt, m_full, m_done;
  int m_len [NUM_SLOTS];

  function automatic stim_t st(input logic srec, input logic splay,
                               input logic stp, input logic tmr,
                               input int sel, input logic loop,
                               input logic des, input logic ser);
    stim_t s;
    s.srec  = srec;
    s.splay = splay;
    s.stp   = stp;
    s.tmr   = tmr;
    s.sel   = 2'(sel);
    s.loop  = loop;
    s.des   = des;
    s.ser   = ser;
    return s;
  endfunction

  function automatic void modelReset();
    m_state = 0;
    m_slot  = 0;
    m_addr  = 0;
    m_cnt   = 0;
    m_full  = 0;
    m_done  = 0;
    for (int i = 0; i < NUM_SLOTS; i++) m_len[i] = 0;
  endfunction

  function automatic void modelStep(input stim_t s);
    bit abort;
    abort  = s.stp || s.tmr;
    m_done = 0;
    if (m_state == 0) begin
      if (s.srec) begin
        m_state = 1;
        m_slot  = int'(s.sel);
        m_addr  = m_slot * DEPTH;
        m_cnt   = 0;
        m_full  = 0;
      end else if (s.splay) begin
        if (m_len[s.sel] == 0) begin
          m_done = 1;
        end else begin
          m_state = 2;
          m_slot  = int'(s.sel);
          m_addr  = m_slot * DEPTH;
          m_cnt   = 0;
        end
      end
    end else if (m_state == 1) begin
      if (s.des) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_len[m_slot] = DEPTH;
          m_full  = 1;
          m_done  = 1;
          m_state = 0;
        end else begin
          m_addr++;
          if (abort) begin
            m_len[m_slot] = m_cnt;
            m_done  = 1;
            m_state = 0;
          end
        end
      end else if (abort) begin
        m_len[m_slot] = m_cnt;
        m_done  = 1;
        m_state = 0;
      end
    end else begin
      if (abort) begin
        m_done  = 1;
        m_state = 0;
      end else if (s.ser) begin
        m_cnt++;
        if (m_cnt == m_len[m_slot]) begin
          if (s.loop) begin
            m_addr = m_slot * DEPTH;
            m_cnt  = 0;
          end else begin
            m_done  = 1;
            m_state = 0;
          end
        end else begin
          m_addr++;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs; capture pre-edge and post-edge outputs.
  task automatic applyStimulus(input stim_t s);
    @(negedge clock);
    bus.start_rec  = s.srec;
    bus.start_play = s.splay;
    bus.stop       = s.stp;
    bus.timer_done = s.tmr;
    bus.slot_sel   = s.sel;
    bus.loop_en    = s.loop;
    bus.des_done   = s.des;
    bus.ser_done   = s.ser;
    #1;
    act_we       = bus.mem_we;
    act_pre_addr = int'(bus.mem_addr);
    exp_we       = (m_state == 1) && s.des;
    exp_pre_addr = m_addr;
    @(posedge clock);
    #1;
    act_busy      = bus.busy;
    act_done      = bus.done;
    act_full      = bus.slot_full;
    act_post_addr = int'(bus.mem_addr);
    modelStep(s);
  endtask

  task automatic runCycle(input stim_t s);
    applyStimulus(s);
    checkOutput("mem_we", act_we, exp_we);
    checkOutput("mem_addr_pre", act_pre_addr, exp_pre_addr);
    checkOutput("busy", act_busy, m_state != 0);
    checkOutput("done", act_done, m_done);
    checkOutput("slot_full", act_full, m_full);
    checkOutput("mem_addr_post", act_post_addr, m_addr);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset          = 1'b1;
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    bus.stop       = 1'b0;
    bus.timer_done = 1'b0;
    bus.slot_sel   = '0;
    bus.loop_en    = 1'b0;
    bus.des_done   = 1'b0;
    bus.ser_done   = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset_addr", bus.mem_addr, 0);
    checkOutput("reset_we", bus.mem_we, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_full", bus.slot_full, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t  vecs [8];
  stim_t idle_s, des_s, ser_s, stop_s;
  logic  we_seen, busy_dropped;

  initial begin
    reset          = 1'b1;
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    bus.stop       = 1'b0;
    bus.timer_done = 1'b0;
    bus.slot_sel   = '0;
    bus.loop_en    = 1'b0;
    bus.des_done   = 1'b0;
    bus.ser_done   = 1'b0;
    modelReset();

    idle_s = st(0, 0, 0, 0, 0, 0, 0, 0);
    des_s  = st(0, 0, 0, 0, 0, 0, 1, 0);
    ser_s  = st(0, 0, 0, 0, 0, 0, 0, 1);
    stop_s = st(0, 0, 1, 0, 0, 0, 0, 0);

    doReset();

    // Table: record slot 2, five samples, then stop.
    vecs[0] = '{st(1, 0, 0, 0, 2, 0, 0, 0), 1'b0, 0, 1'b1, 1'b0, 1'b0, 32};
    for (int k = 0; k < 5; k++)
      vecs[1+k] = '{des_s, 1'b1, 32 + k, 1'b1, 1'b0, 1'b0, 33 + k};
    vecs[6] = '{stop_s, 1'b0, 37, 1'b0, 1'b1, 1'b0, 37};
    vecs[7] = '{idle_s, 1'b0, 37, 1'b0, 1'b0, 1'b0, 37};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput("tbl_we", act_we, vecs[i].we);
      checkOutput("tbl_addr_pre", act_pre_addr, vecs[i].pre_addr);
      checkOutput("tbl_busy", act_busy, vecs[i].busy);
      checkOutput("tbl_done", act_done, vecs[i].done);
      checkOutput("tbl_full", act_full, vecs[i].full);
      checkOutput("tbl_addr_post", act_post_addr, vecs[i].post_addr);
    end

    // Record slot 1 until full; the 17th sample must be ignored.
    runCycle(st(1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      runCycle(des_s);
      if (i == 15) begin
        checkOutput("full_on_16th", act_full, 1);
        checkOutput("done_on_16th", act_done, 1);
        checkOutput("addr_held_full", act_post_addr, 31);
      end
      if (i == 16) checkOutput("we_after_full", act_we, 0);
    end

    // One-shot playback of slot 2.
    runCycle(st(0, 1, 0, 0, 2, 0, 0, 0));
    we_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      runCycle(ser_s);
      we_seen |= act_we;
      checkOutput("play_addr", act_pre_addr, 32 + i);
    end
    checkOutput("play_done", act_done, 1);
    checkOutput("play_we_never", we_seen, 0);

    // Looped playback of slot 2, then stop.
    runCycle(st(0, 1, 0, 0, 2, 1, 0, 0));
    busy_dropped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      runCycle(st(0, 0, 0, 0, 0, 1, 0, 1));
      checkOutput("loop_addr", act_pre_addr, 32 + (i % 5));
      if (!act_busy || act_done) busy_dropped = 1'b1;
    end
    checkOutput("loop_busy_held", busy_dropped, 0);
    runCycle(st(0, 0, 1, 0, 0, 1, 0, 0));
    checkOutput("loop_stop_done", act_done, 1);

    // Simultaneous starts: record wins.
    runCycle(st(1, 1, 0, 0, 3, 0, 0, 0));
    checkOutput("both_start_busy", act_busy, 1);
    runCycle(des_s);
    checkOutput("both_start_we", act_we, 1);
    checkOutput("both_start_addr", act_pre_addr, 48);
    runCycle(st(0, 0, 0, 1, 0, 0, 0, 0));
    checkOutput("timer_done_ends", act_done, 1);

    // Empty slot playback and ignored aborts in IDLE.
    runCycle(st(0, 1, 0, 0, 0, 0, 0, 0));
    checkOutput("empty_play_done", act_done, 1);
    checkOutput("empty_play_busy", act_busy, 0);
    runCycle(st(0, 0, 1, 1, 0, 0, 0, 0));
    checkOutput("idle_stop_no_done", act_done, 0);

    // Reset in the middle of a recording clears lengths.
    runCycle(st(1, 0, 0, 0, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) runCycle(des_s);
    doReset();
    runCycle(idle_s);
    checkOutput("no_done_after_reset", act_done, 0);
    runCycle(st(0, 1, 0, 0, 2, 0, 0, 0));
    checkOutput("len_cleared_done", act_done, 1);
    checkOutput("len_cleared_busy", act_busy, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        doReset();
      end else begin
        runCycle(st($urandom_range(39) == 0, $urandom_range(29) == 0,
                    $urandom_range(59) == 0, $urandom_range(79) == 0,
                    int'($urandom_range(3)), $urandom_range(3) != 0,
                    $urandom_range(1) == 1, $urandom_range(1) == 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
